// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE-chain tile sequencer: state encoding,
// default MAC pipeline latency and the exp_bias width.
package pe_ctrl_pkg;

  localparam int MAC_LAT_DEF = 2;
  localparam int EXP_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Width of a counter that walks 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_ctrl_if.sv
// Handshake, config and status bundle between the tile DMA/buffer logic
// (master) and the PE-chain sequencer (slave).
interface pe_ctrl_if #(
  parameter int N_PE  = 4,
  parameter int ROW_W = 8
) ();

  logic                          start;
  logic                          abort;
  logic [ROW_W-1:0]              cfg_rows;
  logic [pe_ctrl_pkg::EXP_W-1:0] cfg_exp_bias;
  logic                          w_valid;
  logic                          w_ready;
  logic [N_PE-1:0]               w_sel;
  logic                          img_valid;
  logic                          img_ready;
  logic                          img_shift;
  logic [pe_ctrl_pkg::EXP_W-1:0] exp_bias;
  logic                          psum_valid;
  logic [ROW_W-1:0]              row_idx;
  logic                          busy;
  logic                          done;

  modport master (
    output start, abort, cfg_rows, cfg_exp_bias, w_valid, img_valid,
    input  w_ready, w_sel, img_ready, img_shift, exp_bias, psum_valid,
           row_idx, busy, done
  );

  modport slave (
    input  start, abort, cfg_rows, cfg_exp_bias, w_valid, img_valid,
    output w_ready, w_sel, img_ready, img_shift, exp_bias, psum_valid,
           row_idx, busy, done
  );

endinterface

// File: rtl/pe_ctrl_valid_pipe.sv
// valid_pipe: DEPTH-deep shift register that mirrors the MAC pipeline, one bit
// per in-flight image beat; tail marks a valid psum, any gates the drain exit.
module valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  output logic tail,
  output logic any
);

  logic [DEPTH-1:0] line;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line <= '0;
    end else if (clr) begin
      line <= '0;
    end else begin
      line[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        line[i] <= line[i-1];
      end
    end
  end

  assign tail = line[DEPTH-1];
  assign any  = |line;

endmodule

// File: rtl/pe_ctrl.sv
// pe_ctrl: tile sequencer for one PE chain -- walks the weight-load enables,
// streams image beats and flags when the chain's psum_out is valid.
module pe_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int N_PE    = 4,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int ROW_W   = 8
) (
  input logic      clk,
  input logic      rst,
  pe_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_width(N_PE);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] w_cnt;
  logic [ROW_W-1:0] in_cnt;
  logic [ROW_W-1:0] rows_r;
  logic [ROW_W-1:0] row_idx_r;
  logic [EXP_W-1:0] exp_bias_r;

  logic start_ok, w_hs, img_acc;
  logic last_w, last_img, row_last;
  logic pipe_clr, pipe_tail, pipe_any;

  // A start paired with abort is dropped, so abort always wins.
  assign start_ok = (state == ST_IDLE) && bus.start && !bus.abort;
  assign w_hs     = (state == ST_LOAD_W) && bus.w_valid;
  assign img_acc  = (state == ST_STREAM) && bus.img_valid;
  assign last_w   = (w_cnt == CNT_W'(N_PE - 1));
  assign last_img = (in_cnt == rows_r - ROW_W'(1));
  assign row_last = (row_idx_r == rows_r - ROW_W'(1));
  assign pipe_clr = bus.abort && (state != ST_IDLE);

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch
    // is inferred.
    state_nxt = state;
    if (pipe_clr) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (start_ok)           state_nxt = ST_LOAD_W;
        ST_LOAD_W: if (w_hs && last_w)     state_nxt = ST_STREAM;
        ST_STREAM: if (img_acc && last_img) state_nxt = ST_DRAIN;
        ST_DRAIN:  if (!pipe_any)          state_nxt = ST_DONE;
        ST_DONE:                           state_nxt = ST_IDLE;
        default:                           state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Config is captured only on an accepted start; exp_bias then persists
  // through IDLE so the PEs see a stable bias between tiles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_cnt      <= '0;
      in_cnt     <= '0;
      rows_r     <= '0;
      row_idx_r  <= '0;
      exp_bias_r <= '0;
    end else if (state == ST_IDLE) begin
      w_cnt     <= '0;
      in_cnt    <= '0;
      row_idx_r <= '0;
      if (start_ok) begin
        rows_r     <= (bus.cfg_rows == '0) ? ROW_W'(1) : bus.cfg_rows;
        exp_bias_r <= bus.cfg_exp_bias;
      end
    end else begin
      if (w_hs)                   w_cnt     <= w_cnt + CNT_W'(1);
      if (img_acc)                in_cnt    <= in_cnt + ROW_W'(1);
      if (pipe_tail && !row_last) row_idx_r <= row_idx_r + ROW_W'(1);
    end
  end

  valid_pipe #(
    .DEPTH (MAC_LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .rst  (rst),
    .clr  (pipe_clr),
    .push (img_acc),
    .tail (pipe_tail),
    .any  (pipe_any)
  );

  assign bus.w_ready    = (state == ST_LOAD_W);
  assign bus.w_sel      = (state == ST_LOAD_W) ? (N_PE'(1) << w_cnt) : '0;
  assign bus.img_ready  = (state == ST_STREAM);
  assign bus.img_shift  = bus.img_valid && bus.img_ready;
  assign bus.exp_bias   = exp_bias_r;
  assign bus.psum_valid = pipe_tail;
  assign bus.row_idx    = row_idx_r;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);

endmodule
